// File: rtl/div_pkg.sv
// Shared constants for the long-division sequencer: default width,
// alignment counter width and the FSM state encodings.
package div_pkg;

  localparam int DIV_SIZE    = 32;
  localparam int ALIGN_CNT_W = $clog2(DIV_SIZE);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_CHECK  = 4'd2;
  localparam logic [3:0] S_ALIGN  = 4'd3;
  localparam logic [3:0] S_TEST   = 4'd4;
  localparam logic [3:0] S_SHIFT  = 4'd5;
  localparam logic [3:0] S_LATCH  = 4'd6;
  localparam logic [3:0] S_ERR    = 4'd7;
  localparam logic [3:0] S_RESULT = 4'd8;

endpackage

// File: rtl/div_result_reg.sv
// Result capture/hold register: quotient, remainder and div_by_zero are
// loaded from the datapath or the zero-divisor path and held until accepted.
module div_result_reg
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_cap_latch,
  input  logic            i_cap_err,
  input  logic [SIZE-1:0] i_quotient,
  input  logic [SIZE-1:0] i_remainder,
  input  logic [SIZE-1:0] i_dividend,
  input  logic            i_out_ready,
  output logic            o_out_valid,
  output logic [SIZE-1:0] o_quotient,
  output logic [SIZE-1:0] o_remainder,
  output logic            o_div_by_zero
);

  logic            r_valid;
  logic [SIZE-1:0] r_quotient;
  logic [SIZE-1:0] r_remainder;
  logic            r_div_by_zero;

  // Capture on LATCH/ERR, then hold everything until the consumer takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid       <= 1'b0;
      r_quotient    <= {SIZE{1'b0}};
      r_remainder   <= {SIZE{1'b0}};
      r_div_by_zero <= 1'b0;
    end else if (i_cap_latch) begin
      r_valid       <= 1'b1;
      r_quotient    <= i_quotient;
      r_remainder   <= i_remainder;
      r_div_by_zero <= 1'b0;
    end else if (i_cap_err) begin
      r_valid       <= 1'b1;
      r_quotient    <= {SIZE{1'b1}};
      r_remainder   <= i_dividend;
      r_div_by_zero <= 1'b1;
    end else if (r_valid && i_out_ready) begin
      r_valid       <= 1'b0;
    end
  end

  assign o_out_valid   = r_valid;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: rtl/div_control.sv
// Sequencing FSM for the long-division datapath. Optional zero-divisor
// short cut is enabled by defining DIV_ZERO_DETECT_EN.
module div_control
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            in_ready,
  input  logic [SIZE-1:0] divisor_in,
  input  logic [SIZE-1:0] dividend_in,
  output logic [SIZE-1:0] op_divisor,
  output logic [SIZE-1:0] op_dividend,
  output logic            init,
  output logic            left,
  output logic            right,
  output logic            sub,
  input  logic            cnt_is_0,
  input  logic            divisor_is_0,
  input  logic            dvsr_less_than_dvnd,
  input  logic            dvsr_equal_dvnd,
  input  logic            shifted_divisor_MSB,
  input  logic [SIZE-1:0] quotient_in,
  input  logic [SIZE-1:0] remainder_in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int              CW        = $clog2(SIZE);
  localparam logic [CW-1:0]   ALIGN_MAX = CW'(SIZE - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  logic [3:0]      r_state;
  logic [3:0]      w_next_state;
  logic [CW-1:0]   r_align_cnt;
  logic [SIZE-1:0] r_op_divisor;
  logic [SIZE-1:0] r_op_dividend;
  logic            r_in_ready;
  logic            r_busy;
  logic            w_accept;
  logic            w_left_ok;
  logic            w_init;
  logic            w_left;
  logic            w_right;
  logic            w_sub;
  logic            w_out_valid;

  assign w_accept  = start && r_in_ready;
  // The counter cap bounds alignment even when the divisor never overtakes the dividend
  assign w_left_ok = !shifted_divisor_MSB && dvsr_less_than_dvnd && (r_align_cnt < ALIGN_MAX);

`ifndef DIV_ZERO_DETECT_EN
  logic w_unused_div0;
  assign w_unused_div0 = divisor_is_0;
`endif

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_INIT;
        else          w_next_state = S_IDLE;
      end
      S_INIT:  w_next_state = S_CHECK;
      S_CHECK: begin
`ifdef DIV_ZERO_DETECT_EN
        if (divisor_is_0) w_next_state = S_ERR;
        else              w_next_state = S_ALIGN;
`else
        w_next_state = S_ALIGN;
`endif
      end
      S_ALIGN: begin
        if (w_left_ok) w_next_state = S_ALIGN;
        else           w_next_state = S_TEST;
      end
      S_TEST: begin
        if (cnt_is_0) w_next_state = S_LATCH;
        else          w_next_state = S_SHIFT;
      end
      S_SHIFT:  w_next_state = S_TEST;
      S_LATCH:  w_next_state = S_RESULT;
      S_ERR:    w_next_state = S_RESULT;
      S_RESULT: begin
        if (w_out_valid && out_ready) w_next_state = S_IDLE;
        else                          w_next_state = S_RESULT;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath controls follow live status, so they are decoded combinationally
  always_comb begin
    w_init  = 1'b0;
    w_left  = 1'b0;
    w_right = 1'b0;
    w_sub   = 1'b0;
    case (r_state)
      S_INIT:  w_init  = 1'b1;
      S_ALIGN: w_left  = w_left_ok;
      S_TEST:  w_sub   = dvsr_less_than_dvnd || dvsr_equal_dvnd;
      S_SHIFT: w_right = 1'b1;
      default: w_init  = 1'b0;
    endcase
  end

  // State, handshake flags, operand latch and alignment counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
      r_align_cnt   <= {CW{1'b0}};
      r_op_divisor  <= {SIZE{1'b0}};
      r_op_dividend <= {SIZE{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
      r_busy     <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_op_divisor  <= divisor_in;
        r_op_dividend <= dividend_in;
        r_align_cnt   <= {CW{1'b0}};
      end else if (w_left) begin
        r_align_cnt   <= r_align_cnt + CNT_ONE;
      end
    end
  end

  div_result_reg #(.SIZE(SIZE)) u_result (
    .clk           (clk),
    .reset         (reset),
    .i_cap_latch   (r_state == S_LATCH),
    .i_cap_err     (r_state == S_ERR),
    .i_quotient    (quotient_in),
    .i_remainder   (remainder_in),
    .i_dividend    (r_op_dividend),
    .i_out_ready   (out_ready),
    .o_out_valid   (w_out_valid),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign op_divisor  = r_op_divisor;
  assign op_dividend = r_op_dividend;
  assign init        = w_init;
  assign left        = w_left;
  assign right       = w_right;
  assign sub         = w_sub;
  assign out_valid   = w_out_valid;

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control with a behavioural long-division datapath and a
// result scoreboard; expectations track DIV_ZERO_DETECT_EN if defined.
module tb_div_control;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_ready;
  logic [W-1:0] divisor_in, dividend_in;
  logic [W-1:0] op_divisor, op_dividend;
  logic         init, left, right, sub;
  logic         cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, dvsr_equal_dvnd, shifted_divisor_MSB;
  logic [W-1:0] quotient_in, remainder_in;
  logic         busy, out_valid, out_ready, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int   n_vec = 0;
  int   n_err = 0;
  int   multi_ctl = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_control #(.SIZE(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
    .divisor_in(divisor_in), .dividend_in(dividend_in),
    .op_divisor(op_divisor), .op_dividend(op_dividend),
    .init(init), .left(left), .right(right), .sub(sub),
    .cnt_is_0(cnt_is_0), .divisor_is_0(divisor_is_0),
    .dvsr_less_than_dvnd(dvsr_less_than_dvnd), .dvsr_equal_dvnd(dvsr_equal_dvnd),
    .shifted_divisor_MSB(shifted_divisor_MSB),
    .quotient_in(quotient_in), .remainder_in(remainder_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Behavioural datapath driven by the controller
  logic [W-1:0] d_dvsr = '0;
  logic [W-1:0] d_rem  = '0;
  logic [W-1:0] d_quo  = '0;
  int           d_cnt  = 0;

  always @(posedge clk) begin
    if (init) begin
      d_dvsr <= op_divisor; d_rem <= op_dividend; d_quo <= 32'd0; d_cnt <= 0;
    end else if (left) begin
      d_dvsr <= d_dvsr << 1; d_cnt <= d_cnt + 1;
    end else if (right) begin
      d_dvsr <= d_dvsr >> 1; d_cnt <= d_cnt - 1; d_quo <= d_quo << 1;
    end else if (sub) begin
      d_rem <= d_rem - d_dvsr; d_quo <= d_quo | 32'd1;
    end
  end

  assign cnt_is_0            = (d_cnt == 0);
  assign divisor_is_0        = (d_dvsr == 32'd0);
  assign dvsr_less_than_dvnd = (d_dvsr < d_rem);
  assign dvsr_equal_dvnd     = (d_dvsr == d_rem);
  assign shifted_divisor_MSB = d_dvsr[W-1];
  assign quotient_in         = d_quo;
  assign remainder_in        = d_rem;

  always @(negedge clk) begin
    if (reset === 1'b1 && $countones({init, left, right, sub}) > 1) multi_ctl++;
  end

  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t         e;
    int           k = 0;
    logic [W-1:0] d = dvs;
    while (d[W-1] == 1'b0 && d < dvd && k < W-1) begin
      d = d << 1;
      k++;
    end
    if (dvs == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = dvd;
`ifdef DIV_ZERO_DETECT_EN
      e.dbz = 1'b1; e.lat = 3;
`else
      e.dbz = 1'b0; e.lat = 3 * k + 5;
`endif
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0; e.lat = 3 * k + 5;
    end
    return e;
  endfunction

  // Apply one operand pair; returns at the negedge just after the accept edge
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    dividend_in = dvd; divisor_in = dvs; start = 1'b1;
    sb.push_back(model(dvd, dvs));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input string name);
    int   cyc = 0;
    exp_t e;
    while (out_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++; $display("FAIL %s_sb: scoreboard empty, required 1 entry", name);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL %s_timeout: out_valid=%b required 1 within 200 cycles", name, out_valid);
      return;
    end
    n_vec++;
    if (quotient !== e.q) begin
      n_err++; $display("FAIL %s_q: got %h required %h", name, quotient, e.q);
    end
    n_vec++;
    if (remainder !== e.r) begin
      n_err++; $display("FAIL %s_r: got %h required %h", name, remainder, e.r);
    end
    n_vec++;
    if (div_by_zero !== e.dbz) begin
      n_err++; $display("FAIL %s_dbz: got %b required %b", name, div_by_zero, e.dbz);
    end
    n_vec++;
    if (cyc != e.lat) begin
      n_err++; $display("FAIL %s_lat: got %0d required %0d", name, cyc, e.lat);
    end
    if (out_ready === 1'b1) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL %s_xfer: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_vec++;
    if ({in_ready, busy, out_valid, div_by_zero, init, left, right, sub} !== 8'b1000_0000) begin
      n_err++; $display("FAIL %s_flags: got %b required 10000000", name,
                        {in_ready, busy, out_valid, div_by_zero, init, left, right, sub});
    end
    n_vec++;
    if ({quotient, remainder, op_divisor, op_dividend} !== 128'd0) begin
      n_err++; $display("FAIL %s_regs: q=%h r=%h opd=%h opn=%h required all 0", name,
                        quotient, remainder, op_divisor, op_dividend);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    divisor_in = 32'd0; dividend_in = 32'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset");
  endtask

  task automatic test_basic();
    issue(32'd100, 32'd7);          collect("div_100_7");
    issue(32'hFFFF_FFFF, 32'd1);    collect("div_max_1");
    issue(32'd5, 32'd5);            collect("div_5_5");
    issue(32'd3, 32'd9);            collect("div_3_9");
    issue(32'hFFFF_FFFF, 32'h8000_0000); collect("div_msb");
  endtask

  task automatic test_div_zero();
    issue(32'd42, 32'd0);
    collect("div_42_0");
  endtask

  task automatic test_stall();
    logic [W-1:0] q0, r0;
    out_ready = 1'b0;
    issue(32'd100, 32'd7);
    collect("stall");
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; divisor_in = $urandom; dividend_in = $urandom;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: v=%b q=%h r=%h rdy=%b required 1/%h/%h/0",
                          i, out_valid, quotient, remainder, in_ready, q0, r0);
      end
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_xfer: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL stall_noqueue: busy=%b sb=%0d required 0/0", busy, sb.size());
    end
  endtask

  task automatic test_reset_abort();
    issue(32'hFFFF_FFFF, 32'd1);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    n_vec++;
    if (left !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_align: left=%b busy=%b required 1/1", left, busy);
    end
    reset = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_noresult: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    issue(32'd100, 32'd7);
    collect("after_abort");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      issue(a, b);
      collect($sformatf("b2b%0d", i));
    end
  endtask

  task automatic test_controls();
    n_vec++;
    if (multi_ctl != 0) begin
      n_err++; $display("FAIL ctl_onehot: %0d cycles with several controls high, required 0", multi_ctl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_controls();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
